ni_local_port: RTL
==================

Name: ni_local_port

Overview:
- Network interface on the local side of the bufferless DEC router. Drives the router's local injection input (dinLocal, PVLocal) and consumes its local ejection output (doutLocal).
- Injection path: a queue that holds the head flit stable on the router input until the router grants a local slot.
- Ejection path: a buffer that captures ejected flits. The router cannot be back-pressured, so overflow flits are dropped and counted.

Parameters:
- WIDTH_PORT, `WIDTH_PORT, flit width incl. valid/dst fields
- WIDTH_PV, `WIDTH_PV, production vector width
- CORD_X, `CORD_X, this node's X coordinate
- CORD_Y, `CORD_Y, this node's Y coordinate
- INJ_DEPTH, 4, injection FIFO entries (power of 2, ≥2)
- EJ_DEPTH, 4, ejection FIFO entries (power of 2, ≥2)
- STARVE_TH, 15, starvation threshold (optional feature only)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  core injection request
- in_ready  out  1  injection FIFO can accept
- in_flit  in  WIDTH_PORT  core flit; valid bit ignored
- dinLocal  out  WIDTH_PORT  head flit to router local input
- PVLocal  out  WIDTH_PV  production vector of head flit
- inj_grant  in  1  router consumed local flit this cycle
- doutLocal  in  WIDTH_PORT  router ejection flit
- out_valid  out  1  ejected flit available to core
- out_ready  in  1  core accepts ejected flit
- out_flit  out  WIDTH_PORT  ejected flit to core
- drop_cnt  out  16  saturating count of dropped ejections
- starve  out  1  head flit starving (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, reset==0):
  - Both FIFOs empty; dinLocal=0, PVLocal=0, out_valid=0, out_flit=0, drop_cnt=0, starve=0.
  - in_ready=1 as soon as the counts clear; pushes while reset==0 are ignored.
  - Reset mid-operation discards all queued flits.
- Injection push: occurs when in_valid && in_ready at the edge. The stored flit has its POS_VALID bit forced to 1.
- in_ready = !inj_full (combinational from the count). There is no push-when-full, even with a simultaneous pop.
- dinLocal:
  - Non-empty: head flit, driven combinationally from FIFO storage, stable until popped.
  - Empty: all zeros (valid=0).
- PVLocal:
  - Non-empty: rc(CORD_X,CORD_Y) applied to the head {POS_X_DST,POS_Y_DST}.
  - Empty: 0.
- Pop: on inj_grant && non-empty. inj_grant while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged.
  - After a pop, the next head appears on dinLocal in the following cycle (0-bubble back-to-back injection).
- Latency: a flit pushed at edge N is visible on dinLocal after edge N when the FIFO was empty.
- Ejection capture: at each edge, if doutLocal[POS_VALID]==1:
  - Not full, or full with a simultaneous pop: written to the ejection FIFO.
  - Full with no pop in the same cycle: dropped, and drop_cnt increments (saturates at 16'hFFFF).
  - Flits with valid==0 are never stored.
- Ejection output: out_valid = !ej_empty; out_flit = head of the ejection FIFO (0 when empty). Pop on out_valid && out_ready.
  - Latency: a flit sampled at edge N is visible at out_flit after edge N.
- Pointers wrap modulo depth. Counts are log2(DEPTH)+1 bits, so full and empty are unambiguous.

Optional Feature:
- Macro: NI_STARVE_DETECT_EN.
- With the macro defined:
  - 8-bit wait counter increments each cycle the injection FIFO is non-empty and inj_grant==0; saturates at 255.
  - Clears to 0 on a pop or when the FIFO is empty.
  - starve = (wait ≥ STARVE_TH), registered (asserts the cycle after the count reaches STARVE_TH).
- Without the macro: no counter; starve is tied to 0.

Decomposition:
- Shared package global.vh holds WIDTH_PORT, WIDTH_PV, POS_VALID, POS_X_DST, POS_Y_DST, CORD_X, CORD_Y; no new macros besides NI_STARVE_DETECT_EN.
- Reuse the existing rc module for PVLocal.
- One natural sub-module, ni_fifo (parameters WIDTH and DEPTH; outputs full/empty, head data), instantiated twice (injection, ejection).

Test Plan:
1. Reset checks:
   - Assert reset=0 with in_valid=1 → all outputs 0, in_ready=1, no flit stored.
   - Release reset → dinLocal valid=0.
2. Push one flit with dst (CORD_X+1, CORD_Y), inj_grant=0 for 3 cycles:
   - dinLocal holds the flit (valid=1) for 3 cycles; PVLocal equals the rc East vector.
   - Pulse grant → dinLocal=0 next cycle.
3. Push 4 flits, grant=0:
   - in_ready=0 after the 4th; a 5th in_valid is not accepted.
   - grant held high → flits appear in order, one per cycle, with no gaps.
4. Inject valid flits on doutLocal every cycle, out_ready=0, EJ_DEPTH=4:
   - First 4 stored; flits 5–7 dropped → drop_cnt=3.
   - Set out_ready=1 → the 4 flits drain in order.
5. Ejection FIFO full, out_ready=1 and a valid doutLocal in the same cycle → flit stored, drop_cnt unchanged.
6. With NI_STARVE_DETECT_EN, STARVE_TH=15: hold a head flit with grant=0 → starve=1 from the 16th cycle; one grant → starve=0 next cycle.

Source files
------------

// File: rtl/ni_local_port_pkg.sv
// ni_local_port_pkg
// Shared flit-format and node-placement constants for the local network
// interface and its route-computation helper.
//
// Flit layout (WIDTH_PORT = 16):
//   [15]    valid
//   [14:13] x destination
//   [12:11] y destination
//   [10:0]  payload
//
// Production-vector bit order (WIDTH_PV = 5):
//   [0] north (y increasing)
//   [1] east  (x increasing)
//   [2] south
//   [3] west
//   [4] local
package ni_local_port_pkg;

    localparam int WIDTH_PORT = 16;
    localparam int WIDTH_PV   = 5;
    localparam int COORD_W    = 2;

    // Field positions inside a flit; POS_X_DST/POS_Y_DST are the field LSBs.
    localparam int POS_VALID  = 15;
    localparam int POS_X_DST  = 13;
    localparam int POS_Y_DST  = 11;

    // This node's coordinates in the mesh.
    localparam int CORD_X     = 1;
    localparam int CORD_Y     = 1;

    localparam int PV_N = 0;
    localparam int PV_E = 1;
    localparam int PV_S = 2;
    localparam int PV_W = 3;
    localparam int PV_L = 4;

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo
// Small circular FIFO with a combinational head output.
// The count is one bit wider than the pointers, so full and empty are never
// ambiguous. A push while full is accepted only when a pop happens in the same
// cycle. A pop while empty is ignored.
//
// Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      asynchronous active-low reset
//   push   in   1      write din this cycle
//   pop    in   1      drop the head this cycle
//   din    in   WIDTH  write data
//   dout   out  WIDTH  head entry, 0 when empty
//   full   out  1      DEPTH entries held
//   empty  out  1      no entries held
module ni_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the cleared count makes old contents invisible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rc.sv
// rc
// Route computation for the DEC router.
// Given a destination, it marks every productive output direction relative to
// the node at (NODE_X, NODE_Y). The local bit is set only when the destination
// is this node.
//
// Ports:
//   x_dst  in   COORD_W   destination X
//   y_dst  in   COORD_W   destination Y
//   pv     out  WIDTH_PV  production vector
module rc
    import ni_local_port_pkg::*;
#(
    parameter int NODE_X = 0,
    parameter int NODE_Y = 0
) (
    input  logic [COORD_W-1:0]  x_dst,
    input  logic [COORD_W-1:0]  y_dst,
    output logic [WIDTH_PV-1:0] pv
);

    localparam logic [COORD_W-1:0] NX = COORD_W'(NODE_X);
    localparam logic [COORD_W-1:0] NY = COORD_W'(NODE_Y);

    always_comb begin
        pv = '0;
        if (x_dst > NX) pv[PV_E] = 1'b1;
        if (x_dst < NX) pv[PV_W] = 1'b1;
        if (y_dst > NY) pv[PV_N] = 1'b1;
        if (y_dst < NY) pv[PV_S] = 1'b1;
        if (x_dst == NX && y_dst == NY) pv[PV_L] = 1'b1;
    end

endmodule

// File: rtl/ni_local_port.sv
// ni_local_port
// Local-side network interface of the bufferless DEC router.
//  - Injection: the core's flits are queued. The head flit is held stable on
//    dinLocal/PVLocal until the router reports that it consumed it with
//    inj_grant.
//  - Ejection: the router cannot be stalled, so every valid doutLocal flit is
//    captured if there is room. Otherwise it is dropped and counted in
//    drop_cnt, which saturates.
//
// Handshakes: the core-side ports use valid/ready. A transfer happens on a
// rising edge where valid and ready are both high. valid must not depend on
// ready. in_ready and out_valid depend only on the queue counts.
//
// Optional build macro NI_STARVE_DETECT_EN adds a starvation detector. It
// raises starve once the injection head has waited more than STARVE_TH cycles
// without a grant. Without the macro, starve is tied low.
//
// Ports:
//   clk        in   1           clock, rising edge
//   reset      in   1           asynchronous active-low reset
//   in_valid   in   1           core injection request
//   in_ready   out  1           injection queue can accept
//   in_flit    in   WIDTH_PORT  core flit (valid bit ignored, forced to 1)
//   dinLocal   out  WIDTH_PORT  head flit to router local input, 0 when empty
//   PVLocal    out  WIDTH_PV    production vector of head flit, 0 when empty
//   inj_grant  in   1           router consumed the local flit this cycle
//   doutLocal  in   WIDTH_PORT  router ejection flit
//   out_valid  out  1           ejected flit available
//   out_ready  in   1           core accepts ejected flit
//   out_flit   out  WIDTH_PORT  ejected head flit, 0 when empty
//   drop_cnt   out  16          saturating count of dropped ejections
//   starve     out  1           injection head starving
module ni_local_port
    import ni_local_port_pkg::*;
#(
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4
`ifdef NI_STARVE_DETECT_EN
    ,
    parameter int STARVE_TH = 15
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH_PORT-1:0] in_flit,
    output logic [WIDTH_PORT-1:0] dinLocal,
    output logic [WIDTH_PV-1:0]   PVLocal,
    input  logic                  inj_grant,
    input  logic [WIDTH_PORT-1:0] doutLocal,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH_PORT-1:0] out_flit,
    output logic [15:0]           drop_cnt,
    output logic                  starve
);

    localparam logic [WIDTH_PORT-1:0] VALID_MASK = WIDTH_PORT'(1) << POS_VALID;

    // ---------------- injection path ----------------
    logic                  inj_full;
    logic                  inj_empty;
    logic                  inj_push;
    logic                  inj_pop;
    logic [WIDTH_PORT-1:0] inj_head;
    logic [WIDTH_PV-1:0]   rc_pv;

    // A full queue never accepts a push, even when a pop happens in the same cycle.
    assign in_ready = !inj_full;
    assign inj_push = in_valid && !inj_full;
    assign inj_pop  = inj_grant && !inj_empty;

    ni_fifo #(
        .WIDTH (WIDTH_PORT),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inj_push),
        .pop   (inj_pop),
        .din   (in_flit | VALID_MASK),
        .dout  (inj_head),
        .full  (inj_full),
        .empty (inj_empty)
    );

    rc #(
        .NODE_X (CORD_X),
        .NODE_Y (CORD_Y)
    ) u_rc (
        .x_dst (inj_head[POS_X_DST +: COORD_W]),
        .y_dst (inj_head[POS_Y_DST +: COORD_W]),
        .pv    (rc_pv)
    );

    assign dinLocal = inj_head;
    // The zero head of an empty queue still decodes to a direction, so mask it.
    assign PVLocal  = inj_empty ? '0 : rc_pv;

    // ---------------- ejection path ----------------
    logic ej_full;
    logic ej_empty;
    logic ej_push;
    logic ej_pop;
    logic ej_in_valid;
    logic drop;

    assign ej_in_valid = doutLocal[POS_VALID];
    assign ej_pop      = out_ready && !ej_empty;
    // A full queue can still take the incoming flit when the head leaves this cycle.
    assign ej_push     = ej_in_valid && (!ej_full || ej_pop);
    assign drop        = ej_in_valid && ej_full && !ej_pop;

    ni_fifo #(
        .WIDTH (WIDTH_PORT),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ej_push),
        .pop   (ej_pop),
        .din   (doutLocal),
        .dout  (out_flit),
        .full  (ej_full),
        .empty (ej_empty)
    );

    assign out_valid = !ej_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // ---------------- starvation detect ----------------
`ifdef NI_STARVE_DETECT_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_TH);

    logic [7:0] wait_cnt;
    logic       starve_q;

    // Reaching the else branch implies a non-empty queue with no grant.
    // starve follows the count one cycle late, but a pop or an empty queue
    // clears it immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            starve_q <= 1'b0;
        end else if (inj_pop || inj_empty) begin
            wait_cnt <= '0;
            starve_q <= 1'b0;
        end else begin
            starve_q <= (wait_cnt >= STARVE_LIM);
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign starve = starve_q;
`else
    assign starve = 1'b0;
`endif

endmodule
